// File: rtl/alu_pkg.sv
// Shared types for the registered ALU: opcode encoding, flag bundle and control FSM states.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_INC  = 4'd2,
        OP_DEC  = 4'd3,
        OP_MOV  = 4'd4,
        OP_SHL1 = 4'd5,
        OP_SIMD = 4'd6,
        OP_AND  = 4'd7,
        OP_OR   = 4'd8,
        OP_XOR  = 4'd9,
        OP_NOT  = 4'd10,
        OP_NEG  = 4'd11,
        OP_SHL  = 4'd12,
        OP_SHR  = 4'd13,
        OP_MUL  = 4'd14,
        OP_ILL  = 4'd15
    } alu_op_e;

    typedef struct packed {
        logic cf;
        logic of;
        logic zf;
        logic sf;
        logic ef;
    } alu_flags_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add unsigned multiplier, one multiplier bit per cycle for WIDTH cycles.
// done flags the final iteration; product then shows the value being committed on that edge.
module alu_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH);

    logic                 running;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]     mplier;

    assign acc_next = mplier[0] ? (acc + mcand) : acc;
    assign done     = running && (cnt == CNT_W'(WIDTH - 1));
    assign product  = acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            running <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= {{WIDTH{1'b0}}, A};
            mplier  <= B;
        end else if (running) begin
            acc     <= acc_next;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            cnt     <= cnt + CNT_W'(1);
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes; result and flags wait in the output register until taken.
// Optional sequential multiply (op 14) is built only when ALU_PIPE_MUL_EN is defined.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int LANE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Op_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             Cf,
    output logic             Of,
    output logic             Zf,
    output logic             Sf,
    output logic             Ef,
    output logic             busy,
    output logic             state_dbg
);

    localparam int SH_W  = $clog2(WIDTH);
    localparam int LANES = WIDTH / LANE_W;
    localparam logic [WIDTH-1:0] MIN_SIGNED = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_SIGNED = ~MIN_SIGNED;

    alu_op_e          op;
    alu_state_e       state;
    logic             accept;
    logic [WIDTH-1:0] res;
    alu_flags_t       res_flags;
    logic [WIDTH-1:0] out_q;
    alu_flags_t       flags_q;
    logic             mul_start;
    logic             mul_done;
    logic [2*WIDTH-1:0] mul_product;

    // Handshake: a transfer happens on a rising edge where valid && ready on that side.
    // Inputs are taken only when idle and the output slot is empty or being drained this edge,
    // and the output holds Out/flags stable while out_valid && !out_ready.
    assign op        = alu_op_e'(Op_code);
    assign accept    = in_valid && in_ready;
    assign in_ready  = (state == S_IDLE) && (!out_valid || out_ready);
    assign busy      = (state == S_MUL);
    assign state_dbg = state;

    logic [WIDTH:0]   sum;
    logic [LANE_W:0]  lane_sum;
    logic [SH_W-1:0]  sh;
    logic             legal;

    always_comb begin
        res       = '0;
        res_flags = '0;
        sum       = '0;
        lane_sum  = '0;
        legal     = 1'b1;
        sh        = B[SH_W-1:0];
        case (op)
            OP_ADD: begin
                sum          = {1'b0, A} + {1'b0, B};
                res          = sum[WIDTH-1:0];
                res_flags.cf = sum[WIDTH];
                res_flags.of = (A[WIDTH-1] == B[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                res          = A - B;
                res_flags.cf = (A < B);
                res_flags.of = (A[WIDTH-1] != B[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_INC: begin
                sum          = {1'b0, A} + (WIDTH+1)'(1);
                res          = sum[WIDTH-1:0];
                res_flags.cf = sum[WIDTH];
                res_flags.of = (A == MAX_SIGNED);
            end
            OP_DEC: begin
                res          = A - WIDTH'(1);
                res_flags.cf = (A == '0);
                res_flags.of = (A == MIN_SIGNED);
            end
            OP_MOV:  res = A;
            OP_SHL1: begin
                res          = {A[WIDTH-2:0], 1'b0};
                res_flags.cf = A[WIDTH-1];
            end
            OP_SIMD: begin
                // The last lane summed is the top lane, so its carry is the one left for Cf.
                for (int l = 0; l < LANES; l++) begin
                    lane_sum = {1'b0, A[l*LANE_W +: LANE_W]} + {1'b0, B[l*LANE_W +: LANE_W]};
                    res[l*LANE_W +: LANE_W] = lane_sum[LANE_W-1:0];
                end
                res_flags.cf = lane_sum[LANE_W];
            end
            OP_AND:  res = A & B;
            OP_OR:   res = A | B;
            OP_XOR:  res = A ^ B;
            OP_NOT:  res = ~A;
            OP_NEG: begin
                res          = ~A + WIDTH'(1);
                res_flags.cf = (A == '0);
                res_flags.of = (A == MIN_SIGNED);
            end
            OP_SHL: begin
                res          = A << sh;
                res_flags.cf = (sh != '0) && A[SH_W'(WIDTH - int'(sh))];
            end
            OP_SHR: begin
                res          = A >> sh;
                res_flags.cf = (sh != '0) && A[sh - SH_W'(1)];
            end
            default: begin
                legal        = 1'b0;
                res_flags.ef = 1'b1;
            end
        endcase
        if (legal) begin
            res_flags.zf = (res == '0);
            res_flags.sf = res[WIDTH-1];
        end
    end

`ifdef ALU_PIPE_MUL_EN
    alu_state_e state_next;

    assign mul_start = accept && (op == OP_MUL);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .A       (A),
        .B       (B),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (mul_start) state_next = S_MUL;
            S_MUL:  if (mul_done)  state_next = S_IDLE;
        endcase
    end
`else
    assign state       = S_IDLE;
    assign mul_start   = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_product = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_q     <= '0;
            flags_q   <= '0;
        end else if (accept && !mul_start) begin
            out_valid <= 1'b1;
            out_q     <= res;
            flags_q   <= res_flags;
        end else if (mul_done) begin
            out_valid  <= 1'b1;
            out_q      <= mul_product[WIDTH-1:0];
            flags_q.cf <= |mul_product[2*WIDTH-1:WIDTH];
            flags_q.of <= |mul_product[2*WIDTH-1:WIDTH];
            flags_q.zf <= (mul_product[WIDTH-1:0] == '0);
            flags_q.sf <= mul_product[WIDTH-1];
            flags_q.ef <= 1'b0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign Out = out_q;
    assign Cf  = flags_q.cf;
    assign Of  = flags_q.of;
    assign Zf  = flags_q.zf;
    assign Sf  = flags_q.sf;
    assign Ef  = flags_q.ef;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=32, LANE_W=8); exercises the multiply path when ALU_PIPE_MUL_EN is defined.
module tb_alu_pipe;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] out;
        logic [4:0]  fl;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [3:0]  Op_code = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] Out;
    logic        Cf, Of, Zf, Sf, Ef;
    logic        busy;
    logic        state_dbg;
    logic [4:0]  flags;

    int n_checks = 0;
    int n_fail   = 0;
    logic [36:0] exp_q[$];
    vec_t        vecs [0:16];

    assign flags = {Cf, Of, Zf, Sf, Ef};

    alu_pipe #(.WIDTH(32), .LANE_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Op_code   (Op_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Out       (Out),
        .Cf        (Cf),
        .Of        (Of),
        .Zf        (Zf),
        .Sf        (Sf),
        .Ef        (Ef),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one operation for a single edge; returns #1 after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        Op_code  = op;
        A        = a;
        B        = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, busy, state_dbg, Out, flags} !== 39'd0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b busy=%b st=%b out=%h fl=%b want all zero",
                     out_valid, busy, state_dbg, Out, flags);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_ops();
        vecs = '{
            '{4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'b01010},
            '{4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b10100},
            '{4'd1,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 5'b10010},
            '{4'd1,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 5'b01000},
            '{4'd2,  32'h7FFFFFFF, 32'h00000000, 32'h80000000, 5'b01010},
            '{4'd3,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 5'b10010},
            '{4'd4,  32'h12345678, 32'h00000000, 32'h12345678, 5'b00000},
            '{4'd5,  32'h80000001, 32'h00000000, 32'h00000002, 5'b10000},
            '{4'd6,  32'hFF000001, 32'h01000001, 32'h00000002, 5'b10000},
            '{4'd10, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 5'b00010},
            '{4'd11, 32'h80000000, 32'h00000000, 32'h80000000, 5'b01010},
            '{4'd11, 32'h00000000, 32'h00000000, 32'h00000000, 5'b10100},
            '{4'd12, 32'h00000003, 32'h0000001F, 32'h80000000, 5'b10010},
            '{4'd12, 32'h00000005, 32'h00000020, 32'h00000005, 5'b00000},
            '{4'd13, 32'h80000001, 32'h00000001, 32'h40000000, 5'b10000},
            '{4'd13, 32'hC0000000, 32'h0000001F, 32'h00000001, 5'b10000},
            '{4'd15, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 5'b00001}
        };
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            n_checks++;
            if ({out_valid, Out, flags} !== {1'b1, vecs[i].out, vecs[i].fl}) begin
                n_fail++;
                $display("FAIL op_vec%0d (op %0d): got v=%b out=%h fl=%b want v=1 out=%h fl=%b",
                         i, vecs[i].op, out_valid, Out, flags, vecs[i].out, vecs[i].fl);
            end
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ops_drain: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_stall_back_to_back();
        logic [36:0] exp;
        logic [3:0]  ops [0:3];
        logic [31:0] as  [0:3];
        logic [31:0] bs  [0:3];
        ops = '{4'd4, 4'd7, 4'd8, 4'd9};
        as  = '{32'h00000055, 32'hF0F0F0F0, 32'h0F000000, 32'hAAAAAAAA};
        bs  = '{32'h00000000, 32'hFF00FF00, 32'h000000F0, 32'h55555555};
        exp_q.push_back({32'h00000055, 5'b00000});
        exp_q.push_back({32'hF000F000, 5'b00010});
        exp_q.push_back({32'h0F0000F0, 5'b00000});
        exp_q.push_back({32'hFFFFFFFF, 5'b00010});

        @(negedge clk);
        out_ready = 1'b0;
        issue(4'd0, 32'd1, 32'd2);
        @(negedge clk);
        in_valid = 1'b1;
        Op_code  = ops[0];
        A        = as[0];
        B        = bs[0];
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({out_valid, in_ready, Out, flags} !== {1'b1, 1'b0, 32'd3, 5'b00000}) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got v=%b in_ready=%b out=%h fl=%b want v=1 in_ready=0 out=3 fl=00000",
                         c, out_valid, in_ready, Out, flags);
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = 1'b1;
            Op_code   = ops[i];
            A         = as[i];
            B         = bs[i];
            @(posedge clk);
            #1;
            exp = exp_q.pop_front();
            n_checks++;
            if ({out_valid, Out, flags} !== {1'b1, exp}) begin
                n_fail++;
                $display("FAIL b2b%0d: got v=%b out=%h fl=%b want v=1 out=%h fl=%b",
                         i, out_valid, Out, flags, exp[36:5], exp[4:0]);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_drain: got out_valid=%b queue=%0d want 0/0", out_valid, exp_q.size());
        end
    endtask

`ifdef ALU_PIPE_MUL_EN
    task automatic test_mul();
        logic [31:0] ma [0:2];
        logic [31:0] mb [0:2];
        logic [31:0] mo [0:2];
        logic [4:0]  mf [0:2];
        int lat;
        int busy_cnt;
        ma = '{32'h00010000, 32'h00001234, 32'hFFFFFFFF};
        mb = '{32'h00010000, 32'h00000010, 32'hFFFFFFFF};
        mo = '{32'h00000000, 32'h00012340, 32'h00000001};
        mf = '{5'b11100,     5'b00000,     5'b11000};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(4'd14, ma[i], mb[i]);
            n_checks++;
            if ({busy, in_ready, state_dbg} !== 3'b101) begin
                n_fail++;
                $display("FAIL mul%0d_enter: got busy=%b in_ready=%b st=%b want 1/0/1", i, busy, in_ready, state_dbg);
            end
            lat = 1;
            busy_cnt = 0;
            while (!out_valid && lat < 100) begin
                if (busy) busy_cnt++;
                @(posedge clk);
                #1;
                lat++;
            end
            n_checks++;
            if (lat != 33 || busy_cnt != 32 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL mul%0d_timing: got latency=%0d busy_cycles=%0d busy=%b want 33/32/0",
                         i, lat, busy_cnt, busy);
            end
            n_checks++;
            if ({out_valid, Out, flags} !== {1'b1, mo[i], mf[i]}) begin
                n_fail++;
                $display("FAIL mul%0d_result: got v=%b out=%h fl=%b want v=1 out=%h fl=%b",
                         i, out_valid, Out, flags, mo[i], mf[i]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_abort();
        int spurious;
        out_ready = 1'b1;
        issue(4'd14, 32'd3, 32'd5);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, busy, in_ready, Out, flags} !== {3'b001, 37'd0}) begin
            n_fail++;
            $display("FAIL abort_state: got v=%b busy=%b in_ready=%b out=%h fl=%b want 0/0/1 zero",
                     out_valid, busy, in_ready, Out, flags);
        end
        @(negedge clk);
        rst = 1'b0;
        spurious = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) spurious++;
        end
        n_checks++;
        if (spurious != 0) begin
            n_fail++;
            $display("FAIL abort_quiet: got %0d cycles with out_valid/busy want 0", spurious);
        end
        issue(4'd0, 32'd2, 32'd3);
        n_checks++;
        if ({out_valid, Out, flags} !== {1'b1, 32'd5, 5'b00000}) begin
            n_fail++;
            $display("FAIL abort_add: got v=%b out=%h fl=%b want v=1 out=5 fl=00000", out_valid, Out, flags);
        end
    endtask
`else
    task automatic test_mul();
        out_ready = 1'b1;
        issue(4'd14, 32'h00010000, 32'h00010000);
        n_checks++;
        if ({out_valid, busy, Out, flags} !== {2'b10, 32'd0, 5'b00001}) begin
            n_fail++;
            $display("FAIL mul_disabled: got v=%b busy=%b out=%h fl=%b want v=1 busy=0 out=0 fl=00001",
                     out_valid, busy, Out, flags);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_abort();
        out_ready = 1'b0;
        issue(4'd0, 32'd7, 32'd8);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, busy, in_ready, Out, flags} !== {3'b001, 37'd0}) begin
            n_fail++;
            $display("FAIL abort_state: got v=%b busy=%b in_ready=%b out=%h fl=%b want 0/0/1 zero",
                     out_valid, busy, in_ready, Out, flags);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        issue(4'd0, 32'd2, 32'd3);
        n_checks++;
        if ({out_valid, Out, flags} !== {1'b1, 32'd5, 5'b00000}) begin
            n_fail++;
            $display("FAIL abort_add: got v=%b out=%h fl=%b want v=1 out=5 fl=00000", out_valid, Out, flags);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ops();
        test_stall_back_to_back();
        test_mul();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
